// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath/memory.
// The datapath side drives instruction fields and Zero; the FSM drives all controls.
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCEn;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output Op, Funct, Zero,
    input  MemRead, MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal, State
  );

  modport slave (
    input  Op, Funct, Zero,
    output MemRead, MemWrite, IorD, IRWrite, PCEn, RegWrite, RegDst, MemtoReg,
           ALUSrcA, ALUSrcB, PCSrc, ALUControl, Illegal, State
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM of the MIPS multicycle core: Moore-decoded datapath controls,
// ALU decode, and memory strobes for the unified instruction/data memory.
module mc_control_fsm (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.slave  bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       reg_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic       alu_en;
  } ctrl_t;

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic [2:0] alu_ctl;
  logic       funct_bad;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // alu_en marks legal states; codes 12-15 leave it 0 so even ALUControl reads 0.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_en = 1'b1;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ctrl.illegal = 1'b0;
          default:                                       ctrl.illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        ctrl.illegal   = funct_bad;
      end
      S_RTYPEWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b01;
        ctrl.pc_src    = 2'b01;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JEX: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl.alu_en = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctl   = 3'b010;
    funct_bad = 1'b0;
    case (ctrl.alu_op)
      2'b01: alu_ctl = 3'b110;
      2'b10: begin
        case (bus.Funct)
          FN_ADD:  alu_ctl = 3'b010;
          FN_SUB:  alu_ctl = 3'b110;
          FN_AND:  alu_ctl = 3'b000;
          FN_OR:   alu_ctl = 3'b001;
          FN_SLT:  alu_ctl = 3'b111;
          default: funct_bad = 1'b1;
        endcase
      end
      default: alu_ctl = 3'b010;
    endcase
  end

  // Reset masks every output combinationally, so an in-flight strobe dies in the reset cycle.
  assign bus.MemRead    = !reset && ctrl.mem_read;
  assign bus.MemWrite   = !reset && ctrl.mem_write;
  assign bus.IorD       = !reset && ctrl.iord;
  assign bus.IRWrite    = !reset && ctrl.ir_write;
  assign bus.PCEn       = !reset && (ctrl.pc_write || (ctrl.branch && bus.Zero));
  assign bus.RegWrite   = !reset && ctrl.reg_write;
  assign bus.RegDst     = !reset && ctrl.reg_dst;
  assign bus.MemtoReg   = !reset && ctrl.memto_reg;
  assign bus.ALUSrcA    = !reset && ctrl.alu_src_a;
  assign bus.ALUSrcB    = reset ? 2'b00 : ctrl.alu_src_b;
  assign bus.PCSrc      = reset ? 2'b00 : ctrl.pc_src;
  assign bus.ALUControl = (reset || !ctrl.alu_en) ? 3'b000 : alu_ctl;
  assign bus.Illegal    = !reset && ctrl.illegal;
  assign bus.State      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class through its
// state sequence and checks controls against hand-computed values.
module tb_mc_control_fsm;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mc_control_fsm_if bus();

  mc_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance one cycle; sample 1 ns after the edge, plus a mutual-exclusion check
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rd_wr_excl", {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCEn,
            bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB,
            bus.PCSrc, bus.ALUControl, bus.Illegal, bus.State};
  endfunction

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
  logic [2:0] ac_tab [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
  logic       il_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         wcnt;
  int         rwcnt;

  initial begin
    reset     = 1'b1;
    bus.Op    = 6'b100011;
    bus.Funct = 6'd0;
    bus.Zero  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_outs", all_outs(), 32'd0);
      tick();
    end
    reset = 1'b0;
    #1;
    chk("first_state", bus.State, 0);
    chk("first_memrd", bus.MemRead, 1);
    chk("first_irw", bus.IRWrite, 1);
    chk("first_pcen", bus.PCEn, 1);
    chk("first_alusrcb", bus.ALUSrcB, 2'b01);
    chk("first_aluctl", bus.ALUControl, 3'b010);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_s1", bus.State, 1); chk("lw_dec_rd", bus.MemRead, 0);
    chk("lw_dec_srcb", bus.ALUSrcB, 2'b11); chk("lw_dec_ill", bus.Illegal, 0);
    tick(); chk("lw_s2", bus.State, 2); chk("lw_adr_srca", bus.ALUSrcA, 1);
    chk("lw_adr_srcb", bus.ALUSrcB, 2'b10);
    tick(); chk("lw_s3", bus.State, 3); chk("lw_rd", bus.MemRead, 1);
    chk("lw_iord", bus.IorD, 1); chk("lw_rd_rw", bus.RegWrite, 0);
    tick(); chk("lw_s4", bus.State, 4); chk("lw_wb_rw", bus.RegWrite, 1);
    chk("lw_wb_m2r", bus.MemtoReg, 1); chk("lw_wb_dst", bus.RegDst, 0);
    chk("lw_wb_rd", bus.MemRead, 0);
    tick(); chk("lw_end", bus.State, 0);

    // sw: 0,1,2,5,0 with exactly one MemWrite cycle
    bus.Op = 6'b101011;
    wcnt = 0; rwcnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wcnt  += int'(bus.MemWrite);
      rwcnt += int'(bus.RegWrite);
      if (i == 2) begin
        chk("sw_s5", bus.State, 5);
        chk("sw_wr", bus.MemWrite, 1);
        chk("sw_iord", bus.IorD, 1);
      end
    end
    chk("sw_end", bus.State, 0);
    chk("sw_wcnt", wcnt, 1);
    chk("sw_rwcnt", rwcnt, 0);

    // R-type funct sweep including an unsupported funct
    bus.Op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      bus.Funct = fn_tab[k];
      tick(); chk("rt_s1", bus.State, 1); chk("rt_dec_ill", bus.Illegal, 0);
      tick(); chk("rt_s6", bus.State, 6);
      chk("rt_aluctl", bus.ALUControl, ac_tab[k]);
      chk("rt_ill", bus.Illegal, il_tab[k]);
      chk("rt_srca", bus.ALUSrcA, 1); chk("rt_srcb", bus.ALUSrcB, 2'b00);
      tick(); chk("rt_s7", bus.State, 7); chk("rt_rw", bus.RegWrite, 1);
      chk("rt_dst", bus.RegDst, 1); chk("rt_m2r", bus.MemtoReg, 0);
      chk("rt_wb_ill", bus.Illegal, 0);
      tick(); chk("rt_end", bus.State, 0);
    end

    // beq: PCEn follows Zero combinationally
    bus.Op = 6'b000100;
    bus.Zero = 1'b1;
    tick(); chk("beq_s1", bus.State, 1);
    tick(); chk("beq_s8", bus.State, 8);
    chk("beq_pcen_z1", bus.PCEn, 1); chk("beq_pcsrc", bus.PCSrc, 2'b01);
    chk("beq_aluctl", bus.ALUControl, 3'b110);
    bus.Zero = 1'b0;
    #1;
    chk("beq_pcen_z0", bus.PCEn, 0);
    tick(); chk("beq_end", bus.State, 0);

    // j
    bus.Op = 6'b000010;
    tick(); chk("j_s1", bus.State, 1);
    tick(); chk("j_s11", bus.State, 11); chk("j_pcen", bus.PCEn, 1);
    chk("j_pcsrc", bus.PCSrc, 2'b10);
    tick(); chk("j_end", bus.State, 0);

    // addi
    bus.Op = 6'b001000;
    tick(); chk("addi_s1", bus.State, 1);
    tick(); chk("addi_s9", bus.State, 9); chk("addi_srcb", bus.ALUSrcB, 2'b10);
    chk("addi_srca", bus.ALUSrcA, 1);
    tick(); chk("addi_s10", bus.State, 10); chk("addi_rw", bus.RegWrite, 1);
    chk("addi_dst", bus.RegDst, 0); chk("addi_m2r", bus.MemtoReg, 0);
    tick(); chk("addi_end", bus.State, 0);

    // illegal opcode: two-cycle round trip
    bus.Op = 6'b111111;
    tick(); chk("ill_s1", bus.State, 1); chk("ill_flag", bus.Illegal, 1);
    tick(); chk("ill_end", bus.State, 0); chk("ill_clr", bus.Illegal, 0);

    // reset asserted while in MEMWR masks the write strobe
    bus.Op = 6'b101011;
    tick(); tick(); tick();
    chk("rst_s5", bus.State, 5); chk("rst_pre_wr", bus.MemWrite, 1);
    reset = 1'b1;
    #1;
    chk("rst_wr_mask", bus.MemWrite, 0);
    chk("rst_outs", all_outs(), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_after_state", bus.State, 0);
    chk("rst_after_rd", bus.MemRead, 1);
    chk("rst_after_wr", bus.MemWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the MIPS multicycle core, sitting directly upstream of the unified instruction/data memory. It sequences every instruction through fetch, decode, execute, memory and write-back cycles. It generates the memory strobes (MemRead, MemWrite, IorD) plus all datapath enables and mux selects, and decodes the 3-bit ALU control.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- Op  in  6  opcode, Instr[31:26], from the instruction register.
- Funct  in  6  function field, Instr[5:0].
- Zero  in  1  ALU zero flag.
- MemRead, MemWrite  out  1 each  strobes to the unified memory.
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register.
- PCEn  out  1  PC load: PCWrite | (Branch & Zero).
- RegWrite, RegDst, MemtoReg  out  1 each  register file controls.
- ALUSrcA  out  1  ALU A source: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B source: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  next-PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUControl  out  3  ALU operation.
- Illegal  out  1  one-cycle flag for an unsupported opcode or funct.
- State  out  4  current state code, for debug.

## Operation
- State codes:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11
  - Codes 12-15 go to FETCH on the next edge, with all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by Op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other Op -> FETCH, with Illegal=1 in DECODE.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Outputs are Moore-decoded from the state register. Every output not listed below is 0.
  - FETCH: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IorD=0.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: MemWrite=1, IorD=1.
  - RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - JEX: PCSrc=10, PCWrite=1.
- PCWrite, Branch and ALUOp are internal signals.
- ALU decode:
  - ALUOp 00 -> 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 10, by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Any other Funct -> 010, with Illegal=1 in RTYPEEX. The sequence still completes and RTYPEWB still writes.
- MemRead and MemWrite are never high in the same cycle.

## Timing
- Reset:
  - While reset=1, every output including State is forced to 0 combinationally.
  - The rising edge with reset=1 loads FETCH.
  - The first FETCH cycle is the first cycle after reset deasserts.
- Reset mid-instruction: the state is abandoned at the next edge and no partial write-back occurs after that edge. Any strobe active in the reset cycle is masked to 0.
- Latencies, counted in cycles from FETCH to the next FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal opcode 2.
- PCEn is combinational on Zero during BEQEX; it is 1 in that cycle only if Zero=1.
- The memory read is combinational, so ReadData in FETCH/MEMRD is captured by IR/MDR at the closing edge of that cycle.
- MemWrite is high for exactly one cycle per sw.

## Test plan
- Reset held 3 cycles, then released -> all outputs 0 during reset; State=0 with MemRead=1, IRWrite=1, PCEn=1 in the first cycle after release.
- Op=100011 -> State sequence 0,1,2,3,4,0; MemRead=1 in states 0 and 3; IorD=1 in state 3; RegWrite=1 with MemtoReg=1 only in state 4.
- Op=101011 -> sequence 0,1,2,5,0; MemWrite=1 for exactly one cycle, in state 5; RegWrite never 1.
- Op=000000 with Funct in {100000, 100010, 100100, 100101, 101010} -> ALUControl in RTYPEEX equals 010, 110, 000, 001, 111 respectively; Funct=000111 -> Illegal=1, ALUControl=010.
- Op=000100: Zero=1 -> PCEn=1 with PCSrc=01 in BEQEX; Zero=0 -> PCEn=0. Op=000010 -> PCEn=1 with PCSrc=10 in JEX.
- Op=111111 -> Illegal=1 in DECODE, FETCH on the next cycle. Reset asserted in MEMWR -> MemWrite=0 that cycle and State=0 on the following cycle.
